// File: rtl/pong_match_controller_pkg.sv
// pong_match_controller_pkg: shared Pong state codes, winner codes, key bytes and score helpers
package pong_match_controller_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_POINT = 3'd4,
    S_OVER  = 3'd5
  } state_e;
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1 = 2'b01;
  localparam logic [1:0] WIN_P2 = 2'b10;
  localparam logic [7:0] KEY_W = 8'h77;
  localparam logic [7:0] KEY_S = 8'h73;
  localparam logic [7:0] KEY_I = 8'h69;
  localparam logic [7:0] KEY_K = 8'h6B;
  localparam logic [7:0] KEY_SPACE = 8'h20;
  localparam logic [7:0] KEY_P = 8'h70;
  localparam int SCORE_W = 4;
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/pong_match_controller_frame_tick_gen.sv
// frame_tick_gen: one-cycle tick on each falling edge of the active-low vertical sync
module frame_tick_gen (
  input  logic i_CLK,
  input  logic i_RST_N,
  input  logic i_vSync,
  output logic o_tick
);
  logic vs_q;
  // vSync history, preset to the inactive (high) sync level
  always_ff @(posedge i_CLK or negedge i_RST_N)
    if (!i_RST_N) vs_q <= 1'b1;
    else vs_q <= i_vSync;
  assign o_tick = vs_q & ~i_vSync;
endmodule

// File: rtl/pong_match_controller.sv
// pong_match_controller: Pong match sequencer owning score, match FSM and per-frame engine steps
module pong_match_controller
  import pong_match_controller_pkg::*;
#(
  parameter int WIN_SCORE = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter logic [7:0] KEY_START = KEY_SPACE,
  parameter logic [7:0] KEY_PAUSE = KEY_P
) (
  input  logic         i_CLK,
  input  logic         i_RST_N,
  input  logic         i_vSync,
  input  logic         i_DataValid,
  input  logic [7:0]   i_Rx_Byte,
  input  logic         i_p1_scored,
  input  logic         i_p2_scored,
  output logic         o_paddle_step,
  output logic         o_ball_step,
  output logic         o_ball_reset,
  output logic         o_serve_dir,
  output logic [3:0]   o_p1_score,
  output logic [3:0]   o_p2_score,
  output logic [2:0]   o_state,
  output logic [1:0]   o_winner
);
  localparam int CW = $clog2((SERVE_FRAMES > POINT_FRAMES ? SERVE_FRAMES : POINT_FRAMES) + 1);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic [1:0] win_q, win_d;
  logic dir_q, dir_d, pstep_q, pstep_d, bstep_q, bstep_d, brst_q, brst_d;
  logic tick, key_start, key_pause;
  frame_tick_gen u_tick (
    .i_CLK   (i_CLK),
    .i_RST_N (i_RST_N),
    .i_vSync (i_vSync),
    .o_tick  (tick)
  );
  assign key_start = i_DataValid && (i_Rx_Byte == KEY_START);
  assign key_pause = i_DataValid && (i_Rx_Byte == KEY_PAUSE);
  // match state register
  always_ff @(posedge i_CLK or negedge i_RST_N)
    if (!i_RST_N) state_q <= S_IDLE;
    else state_q <= state_d;
  // next state with counter, score, serve direction and winner updates
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    p1_d = p1_q;
    p2_d = p2_q;
    dir_d = dir_q;
    win_d = win_q;
    case (state_q)
      S_IDLE, S_OVER:
        if (key_start) begin
          p1_d = '0;
          p2_d = '0;
          win_d = WIN_NONE;
          dir_d = 1'b0;
          cnt_d = CW'(SERVE_FRAMES);
          state_d = S_SERVE;
        end
      S_SERVE:
        if (tick) begin
          if (cnt_q == CW'(1)) state_d = S_PLAY;
          else cnt_d = cnt_q - 1'b1;
        end
      S_PLAY:
        if (i_p1_scored) begin
          p1_d = sat_inc(p1_q);
          dir_d = 1'b1;
          cnt_d = CW'(POINT_FRAMES);
          state_d = (p1_d == WIN) ? S_OVER : S_POINT;
          win_d = (p1_d == WIN) ? WIN_P1 : win_q;
        end else if (i_p2_scored) begin
          p2_d = sat_inc(p2_q);
          dir_d = 1'b0;
          cnt_d = CW'(POINT_FRAMES);
          state_d = (p2_d == WIN) ? S_OVER : S_POINT;
          win_d = (p2_d == WIN) ? WIN_P2 : win_q;
        end else if (key_pause) state_d = S_PAUSE;
      S_PAUSE:
        if (key_pause) state_d = S_PLAY;
      S_POINT:
        if (tick) begin
          if (cnt_q == CW'(1)) begin
            cnt_d = CW'(SERVE_FRAMES);
            state_d = S_SERVE;
          end else cnt_d = cnt_q - 1'b1;
        end
      default: state_d = S_IDLE;
    endcase
  end
  // output decode: steps follow the current state, ball reset tracks the state being entered
  always_comb begin
    pstep_d = tick && (state_q == S_SERVE || state_q == S_PLAY);
    bstep_d = tick && (state_q == S_PLAY);
    brst_d = !(state_d == S_PLAY || state_d == S_PAUSE);
  end
  // datapath and registered outputs
  always_ff @(posedge i_CLK or negedge i_RST_N)
    if (!i_RST_N) begin
      cnt_q <= '0;
      p1_q <= '0;
      p2_q <= '0;
      win_q <= WIN_NONE;
      dir_q <= 1'b0;
      pstep_q <= 1'b0;
      bstep_q <= 1'b0;
      brst_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      p1_q <= p1_d;
      p2_q <= p2_d;
      win_q <= win_d;
      dir_q <= dir_d;
      pstep_q <= pstep_d;
      bstep_q <= bstep_d;
      brst_q <= brst_d;
    end
  assign o_state = state_q;
  assign o_p1_score = p1_q;
  assign o_p2_score = p2_q;
  assign o_winner = win_q;
  assign o_serve_dir = dir_q;
  assign o_paddle_step = pstep_q;
  assign o_ball_step = bstep_q;
  assign o_ball_reset = brst_q;
endmodule
